quad_gen: RTL and testbench

Quadrature encoder emulator: produces a two-phase Gray-coded quad1/quad2 pair that walks an internal 7-bit position toward a requested target at a programmable step rate. It is the transmit-side counterpart of the paddle quadrature decoder. It drives emulated paddle/spinner inputs from a host-supplied target, such as OSD or USB, so the downstream decoder tracks the same position. Single clock domain; quad outputs are registered and glitch-free.

---
 rtl/quad_gen.sv | 145 ++++++++++++++
 tb/tb_quad_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder emulator.
// Walks a 7-bit position toward a latched target, emitting one Gray-coded
// {quad1,quad2} edge every step_div+1 clocks, so that a downstream paddle
// quadrature decoder tracks the same position.
// Optional feature: define QUAD_GEN_DONE_EN to add the one-cycle `done` pulse.
module quad_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       target,
    input  logic             target_valid,
    input  logic [DIV_W-1:0] step_div,
    output logic             quad1,
    output logic             quad2,
    output logic [6:0]       pos,
    output logic             busy
`ifdef QUAD_GEN_DONE_EN
    ,
    output logic             done
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;   // {quad1, quad2}
    logic [6:0]       tgt_q,   tgt_d;
    logic [6:0]       pos_q,   pos_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;

    // Up walks 00->01->11->10. With equal phase bits phase B leads, otherwise
    // phase A toggles, so old quad1 XOR new quad2 is always 1 when counting up.
    function automatic logic [1:0] phase_up(input logic [1:0] p);
        return (p[1] ^ p[0]) ? {~p[1], p[0]} : {p[1], ~p[0]};
    endfunction

    // Down is the exact reverse of up.
    function automatic logic [1:0] phase_down(input logic [1:0] p);
        return (p[1] ^ p[0]) ? {p[1], ~p[0]} : {~p[1], p[0]};
    endfunction

    // State register: FSM state, phase, latched target, position and divider.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 2'b00;
            tgt_q   <= 7'd0;
            pos_q   <= 7'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tgt_q   <= tgt_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: target latching, step cadence and the step itself.
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tgt_d   = tgt_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (target_valid) begin
                    tgt_d = target;
                    if (target != pos_q) begin
                        state_d = MOVE;
                        cnt_d   = step_div;
                    end
                end
            end
            MOVE: begin
                if (target_valid && (target == pos_q)) begin
                    // Retarget onto the current position: stop without stepping.
                    tgt_d   = target;
                    state_d = IDLE;
                end else begin
                    if (cnt_q == '0) begin
                        // A due step still heads toward the old target.
                        cnt_d = step_div;
                        if (tgt_q > pos_q) begin
                            pos_d   = pos_q + 7'd1;
                            phase_d = phase_up(phase_q);
                        end else begin
                            pos_d   = pos_q - 7'd1;
                            phase_d = phase_down(phase_q);
                        end
                    end else begin
                        // Divider is never reloaded by a retarget, keeping cadence.
                        cnt_d = cnt_q - DIV_W'(1);
                    end
                    if (target_valid) begin
                        tgt_d = target;
                    end
                    if (pos_d == tgt_d) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: all outputs come straight from registers.
    always_comb begin
        quad1 = phase_q[1];
        quad2 = phase_q[0];
        pos   = pos_q;
        busy  = (state_q == MOVE);
    end

`ifdef QUAD_GEN_DONE_EN
    logic done_q, done_d;

    // Completion detect: a move ends, or an idle target equals the position.
    always_comb begin
        done_d = ((state_q == MOVE) && (state_d == IDLE)) ||
                 ((state_q == IDLE) && target_valid && (target == pos_q));
    end

    // Register the completion pulse so it lines up with busy falling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: randomized self-checking bench for quad_gen against a
// cycle-level behavioural model, plus directed up/down/retarget/reset moves
// and a behavioural quadrature decoder in loopback.
module tb_quad_gen;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       target;
    logic             target_valid;
    logic [DIV_W-1:0] step_div;
    logic             quad1, quad2;
    logic [6:0]       pos;
    logic             busy;
`ifdef QUAD_GEN_DONE_EN
    logic             done;
`endif

    quad_gen #(.DIV_W(DIV_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .target_valid (target_valid),
        .step_div     (step_div),
        .quad1        (quad1),
        .quad2        (quad2),
        .pos          (pos),
        .busy         (busy)
`ifdef QUAD_GEN_DONE_EN
        ,
        .done         (done)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: phase index counts steps mod 4 along the up sequence.
    logic [1:0] ph_code [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int m_pos, m_tgt, m_cnt, m_ph;
    bit m_busy, m_done;

    // Edge log and loopback decoder, built from the observed outputs.
    logic [1:0] prev_code;
    logic [1:0] e_code[$];
    int         e_cyc[$];
    int         dec_pos;
    int         cyc = 0;

    task automatic model_reset();
        m_pos = 0; m_tgt = 0; m_cnt = 0; m_ph = 0; m_busy = 0; m_done = 0;
        prev_code = 2'b00; dec_pos = 0;
        e_code.delete(); e_cyc.delete();
    endtask

    task automatic model_step();
        int dir;
        m_done = 0;
        if (!m_busy) begin
            if (target_valid) begin
                m_tgt = target;
                if (int'(target) != m_pos) begin
                    m_busy = 1;
                    m_cnt  = int'(step_div);
                end else begin
                    m_done = 1;
                end
            end
        end else if (target_valid && int'(target) == m_pos) begin
            m_tgt = target; m_busy = 0; m_done = 1;
        end else begin
            if (m_cnt == 0) begin
                dir   = (m_tgt > m_pos) ? 1 : -1;
                m_pos = m_pos + dir;
                m_ph  = (m_ph + dir + 4) % 4;
                m_cnt = int'(step_div);
            end else begin
                m_cnt = m_cnt - 1;
            end
            if (target_valid) m_tgt = target;
            if (m_pos == m_tgt) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    // One clock: advance the model at the edge, then sample the DUT 1ns later.
    task automatic cycle();
        logic [1:0] code;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        code = {quad1, quad2};
        check("quad", 32'(code), 32'(ph_code[m_ph]));
        check("pos", 32'(pos), m_pos);
        check("busy", 32'(busy), 32'(m_busy));
`ifdef QUAD_GEN_DONE_EN
        check("done", 32'(done), 32'(m_done));
`endif
        if (code != prev_code) begin
            if (prev_code[1] ^ code[0]) dec_pos++;
            else                        dec_pos--;
            e_code.push_back(code);
            e_cyc.push_back(cyc);
            prev_code = code;
        end
    endtask

    task automatic strobe(input int t);
        target = 7'(t);
        target_valid = 1'b1;
        cycle();
        target_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            cycle();
            n++;
        end
        check("settle", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"}, 32'({quad1, quad2}), 0);
        check({tag, "_pos"}, 32'(pos), 0);
        check({tag, "_busy"}, 32'(busy), 0);
`ifdef QUAD_GEN_DONE_EN
        check({tag, "_done"}, 32'(done), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        target_valid = 1'b0;
        #2;
        model_reset();
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Checks an edge log against an expected code list and fixed spacing.
    task automatic check_edges(input string tag, input logic [1:0] exp_codes[$],
                               input int first_cyc, input int period);
        check({tag, "_count"}, e_code.size(), exp_codes.size());
        if (e_code.size() == exp_codes.size()) begin
            for (int i = 0; i < exp_codes.size(); i++) begin
                check({tag, "_code"}, 32'(e_code[i]), 32'(exp_codes[i]));
                check({tag, "_time"}, e_cyc[i], first_cyc + i * period);
            end
        end
    endtask

    initial begin
        logic [1:0] seq[$];
        int k, last;
        reset = 1'b0; target = '0; target_valid = 1'b0; step_div = '0;
        model_reset();
        do_reset();

        // Reset then idle for 100 cycles: no edges.
        repeat (100) cycle();
        check("idle_edges", e_code.size(), 0);

        // Up move: step_div=3, target 5.
        step_div = 16'd3;
        e_code.delete(); e_cyc.delete();
        strobe(5);
        k = cyc;
        run_until_idle(200);
        seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        check_edges("up", seq, k + 4, 4);
        check("up_pos", 32'(pos), 5);
        if (e_cyc.size() > 0) check("up_busy_fall", cyc, e_cyc[e_cyc.size() - 1]);

`ifdef QUAD_GEN_DONE_EN
        // Target equal to position while idle: done pulses once, no move.
        strobe(5);
        check("done_same", 32'(done), 1);
        cycle();
        check("done_same_end", 32'(done), 0);
`endif

        // Down move: from 5 to 2 with step_div=0.
        step_div = 16'd0;
        e_code.delete(); e_cyc.delete();
        strobe(2);
        k = cyc;
        run_until_idle(50);
        seq = '{2'b00, 2'b10, 2'b11};
        check_edges("down", seq, k + 1, 1);
        check("down_pos", 32'(pos), 2);

        // Retarget mid-move: 0 -> 20 at step_div=9, switched to 3 at pos 6.
        do_reset();
        step_div = 16'd9;
        strobe(20);
        for (int i = 0; i < 200 && m_pos != 6; i++) cycle();
        check("rt_reach6", 32'(pos), 6);
        last = (e_cyc.size() > 0) ? e_cyc[e_cyc.size() - 1] : 0;
        e_code.delete(); e_cyc.delete();
        strobe(3);
        run_until_idle(200);
        seq = '{2'b01, 2'b00, 2'b10};
        check_edges("rt", seq, last + 10, 10);
        check("rt_pos", 32'(pos), 3);

        // Async reset between clock edges in the middle of a move.
        step_div = 16'd2;
        strobe(50);
        repeat (15) cycle();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("async");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) cycle();
        check("async_no_edges", e_code.size(), 0);

        // Randomized moves with mid-move retargets and divider changes.
        for (int n = 0; n < 40; n++) begin
            int budget;
            step_div = 16'($urandom_range(5));
            strobe($urandom_range(127));
            budget = 3000;
            while (m_busy && budget > 0) begin
                if ($urandom_range(39) == 0) step_div = 16'($urandom_range(5));
                if ($urandom_range(59) == 0) begin
                    target = ($urandom_range(2) == 0) ? 7'(m_pos) : 7'($urandom_range(127));
                    target_valid = 1'b1;
                end
                cycle();
                target_valid = 1'b0;
                budget--;
            end
            check("rand_settle", 32'(busy), 0);
            check("loopback", dec_pos, m_pos);
            repeat ($urandom_range(3)) cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
